// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory target with fixed wait states and one response pulse per request.
// Stores commit on the edge entering RESP; the old word is returned alongside.
module dmem_responder #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 7,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d, err_q, err_d;
  logic [15:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic accept, commit, c_we, c_in;
  logic [15:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  always_comb begin
    req_ready = rst && state_q == IDLE;
    busy      = state_q != IDLE;
    rsp_valid = state_q == RESP;
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    accept    = req_valid && req_ready;
    commit    = (accept && WAIT_CYC == 0) || (state_q == WAIT && cnt_q == 4'd0);
    // With zero wait states the commit edge is the acceptance edge, so use the live request.
    c_we      = state_q == IDLE ? req_we : we_q;
    c_addr    = state_q == IDLE ? req_addr : addr_q;
    c_wdata   = state_q == IDLE ? req_wdata : wdata_q;
    c_in      = c_addr[15:ADDR_W] == '0;
    state_d   = state_q == RESP ? IDLE : commit ? RESP : accept ? WAIT : state_q;
    cnt_d     = accept ? 4'(WAIT_CYC - 1) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
    we_d      = accept ? req_we : we_q;
    addr_d    = accept ? req_addr : addr_q;
    wdata_d   = accept ? req_wdata : wdata_q;
    rdata_d   = commit ? (c_in ? mem_q[c_addr[ADDR_W-1:0]] : '0) : rdata_q;
    err_d     = commit ? !c_in : err_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit && c_we && c_in) begin
      mem_q[c_addr[ADDR_W-1:0]] <= c_wdata;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized requests against an array-based memory model.
module tb_dmem_responder;
  localparam int W = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;
  logic z_valid = 1'b0, z_we = 1'b0;
  logic [15:0] z_addr = '0, z_wdata = '0;
  logic z_ready, z_rsp_valid, z_err, z_busy;
  logic [15:0] z_rdata;
  int checks = 0, errors = 0;
  logic [15:0] model [128];

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(16), .ADDR_W(7), .WAIT_CYC(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy));

  dmem_responder #(.DATA_W(16), .ADDR_W(7), .WAIT_CYC(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we),
    .req_addr(z_addr), .req_wdata(z_wdata), .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata),
    .rsp_err(z_err), .busy(z_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_access(input logic we, input logic [15:0] a, input logic [15:0] d,
                            output logic [15:0] rd, output logic err);
    err = a >= 16'd128;
    rd  = err ? 16'h0 : model[a[6:0]];
    if (!err && we) model[a[6:0]] = d;
  endtask

  task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] erd;
    logic eerr;
    ref_access(we, a, d, erd, eerr);
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i <= W + 1; i++) begin
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
      if (i < W) begin
        chk("wait_valid", rsp_valid, 0);
        chk("wait_busy", busy, 1);
        chk("wait_ready", req_ready, 0);
      end else if (i == W) begin
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_busy", busy, 1);
        chk("rsp_ready", req_ready, 0);
        chk("rsp_rdata", rsp_rdata, erd);
        chk("rsp_err", rsp_err, eerr);
      end else begin
        chk("post_valid", rsp_valid, 0);
        chk("post_busy", busy, 0);
        chk("hold_rdata", rsp_rdata, erd);
        chk("hold_err", rsp_err, eerr);
      end
    end
  endtask

  initial begin
    int acc[$];
    int pulses;
    logic prev;
    logic [15:0] zd;
    for (int i = 0; i < 128; i++) model[i] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_ready", req_ready, 1);

    do_req(1'b0, 16'd5, 16'h0);
    do_req(1'b1, 16'h0023, 16'hBEEF);
    do_req(1'b0, 16'h0023, 16'h0);
    do_req(1'b1, 16'h0080, 16'h1234);
    do_req(1'b0, 16'h0000, 16'h0);

    pulses = 0; prev = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0023;
    for (int i = 0; i < 12; i++) begin
      if (req_ready) acc.push_back(i);
      if (rsp_valid) begin
        pulses++;
        chk("held_rdata", rsp_rdata, model[35]);
        chk("held_width", prev, 0);
      end
      prev = rsp_valid;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("held_accepts", acc.size(), 3);
    chk("held_pulses", pulses, 3);
    if (acc.size() == 3) begin
      chk("held_acc0", acc[0], 0);
      chk("held_acc1", acc[1], W + 2);
      chk("held_acc2", acc[2], 2 * (W + 2));
    end

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd7; req_wdata = 16'h00FF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_busy", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_rdata", rsp_rdata, 0);
    for (int i = 0; i < 128; i++) model[i] = 16'h0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_after_valid", rsp_valid, 0);
    chk("mid_after_busy", busy, 0);
    chk("mid_after_ready", req_ready, 1);
    do_req(1'b0, 16'd7, 16'h0);

    zd = 16'($urandom) | 16'h1;
    @(negedge clk);
    chk("z_ready0", z_ready, 1);
    z_valid = 1'b1; z_we = 1'b1; z_addr = 16'd9; z_wdata = zd;
    @(negedge clk);
    chk("z_rsp1", z_rsp_valid, 1);
    chk("z_rdata1", z_rdata, 0);
    chk("z_err1", z_err, 0);
    chk("z_ready1", z_ready, 0);
    chk("z_busy1", z_busy, 1);
    z_we = 1'b0;
    @(negedge clk);
    chk("z_rsp2", z_rsp_valid, 0);
    chk("z_ready2", z_ready, 1);
    chk("z_busy2", z_busy, 0);
    @(negedge clk);
    chk("z_rsp3", z_rsp_valid, 1);
    chk("z_rdata3", z_rdata, zd);
    z_valid = 1'b0;
    @(negedge clk);
    chk("z_rsp4", z_rsp_valid, 0);

    repeat (40) begin
      logic [15:0] a, d;
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
      d = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      do_req(1'($urandom), a, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory target: the responder end of the CPU's load/store interface, for the multi-cycle CPU revision.
- Holds DEPTH x DATA_W words and accepts one request at a time over a valid/ready request channel.
- After a fixed, programmable number of wait states, it returns exactly one single-cycle response pulse per accepted request.
- Replaces the zero-latency combinational-read data memory wherever memory latency must be modelled.

Parameters:
- DATA_W, 16, word width of storage, write data and read data.
- ADDR_W, 7, index bits used for storage; DEPTH = 2**ADDR_W = 128 words.
- WAIT_CYC, 2, wait states between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  initiator has a request on req_* this cycle.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  16  word address; full 16-bit CPU address.
- req_wdata  input  DATA_W  store data.
- rsp_valid  output  1  one-cycle pulse; response fields are valid.
- rsp_rdata  output  DATA_W  load: word at address; store: word at address before the write.
- rsp_err  output  1  qualifies rsp_valid; address out of range.
- busy  output  1  a request is in flight (state != IDLE).

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE, wait counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - All DEPTH words are cleared to 0.
  - req_ready = 0 while rst is low, and 1 from the first cycle after release.
- FSM states:
  - IDLE: req_ready = 1. On req_valid & req_ready at an edge, latch we/addr/wdata. Go to WAIT with counter = WAIT_CYC-1, or directly to RESP if WAIT_CYC = 0.
  - WAIT: req_ready = 0. Decrement the counter each edge; go to RESP on the edge where the counter = 0.
  - RESP: rsp_valid = 1 for exactly this one cycle, req_ready = 0. The next edge returns to IDLE.
- Latency: a request accepted at edge N gives rsp_valid high in the cycle after edge N+WAIT_CYC. The next acceptance is possible at edge N+WAIT_CYC+2, so peak throughput is one request per WAIT_CYC+2 cycles.
- Commit edge (the edge entering RESP):
  - The store write happens here.
  - rsp_rdata and rsp_err are registered here from the latched request.
  - A store reads the old contents into rsp_rdata and then writes wdata.
- Range check: the address is in range iff req_addr[15:ADDR_W] == 0.
  - Out of range: rsp_err = 1, rsp_rdata = 0, storage unchanged.
  - In range: rsp_err = 0.
- rsp_rdata and rsp_err hold their values after the RESP cycle until the next commit. Only rsp_valid qualifies them.
- No response back-pressure: the initiator must sample in the RESP cycle.
- req_* inputs are ignored outside IDLE; a held req_valid is not double-accepted.
- Simultaneous events: req_valid that is high in the RESP cycle is not accepted. It is accepted at the edge after that cycle, when the state is IDLE.
- Reset mid-operation: a request that has not reached its commit edge is dropped, and no write occurs. Memory is cleared regardless.
- busy = 1 in WAIT and RESP, and 0 in IDLE.
- A zero data word is a legal store value; there is no special casing of address 0.

Test Plan:
- Reset, then load from addr 5 (WAIT_CYC=2) -> rsp_valid pulses 3 cycles after the acceptance edge; rsp_rdata = 0x0000, rsp_err = 0, busy high for 3 cycles.
- Store 0xBEEF to addr 0x0023, then load addr 0x0023 -> store response rsp_rdata = 0x0000; load response rsp_rdata = 0xBEEF.
- Store 0x1234 to addr 0x0080 (out of range) -> rsp_err = 1, rsp_rdata = 0. A subsequent load of addr 0x0000 returns 0x0000 (no aliasing).
- req_valid held high for 12 cycles with WAIT_CYC=2 -> exactly 3 acceptances at 4-cycle spacing and 3 rsp_valid pulses, each one cycle wide.
- Store 0x00FF to addr 7 accepted, rst pulsed low one cycle later (before the commit edge) -> no rsp_valid, busy = 0; a load of addr 7 after release returns 0x0000.
- WAIT_CYC=0 build: load accepted at edge N -> rsp_valid in the cycle after edge N; next acceptance at edge N+2.
